// File: rtl/peripheral_bb_pkg.sv
// Shared AHB-Lite constants and the slave FSM state type.
// The WAIT state exists only when PERIPHERAL_SLAVE_WAIT_STATES_EN is defined.
package peripheral_bb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HSIZE_HWORD   = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HSIZE_DWORD   = 3'b011;
  localparam logic [2:0] HSIZE_4WLINE  = 3'b100;
  localparam logic [2:0] HSIZE_8WLINE  = 3'b101;
  localparam logic [2:0] HSIZE_16WLINE = 3'b110;
  localparam logic [2:0] HSIZE_32WLINE = 3'b111;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

`ifdef PERIPHERAL_SLAVE_WAIT_STATES_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } slv_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } slv_state_e;
`endif

endpackage

// File: rtl/peripheral_ram_bb.sv
// Single-port byte-enabled RAM: synchronous write, combinational read.
// No reset: contents survive a bus reset.
module peripheral_ram_bb #(
  parameter int DEPTH  = 256,
  parameter int ABITS  = 8,
  parameter int DBYTES = 4
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ABITS-1:0]      addr_i,
  input  logic [DBYTES-1:0]     be_i,
  input  logic [DBYTES*8-1:0]   wdata_i,
  output logic [DBYTES*8-1:0]   rdata_o
);

  logic [DBYTES*8-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < DBYTES; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/peripheral_slave_memory_bb.sv
// AHB-Lite memory slave with ERROR responses for out-of-range, oversized or misaligned accesses.
// Define PERIPHERAL_SLAVE_WAIT_STATES_EN to insert WAIT_STATES wait cycles per OKAY data phase.
module peripheral_slave_memory_bb
  import peripheral_bb_pkg::*;
#(
  parameter int HADDR_SIZE  = 16,
  parameter int HDATA_SIZE  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HMASTLOCK,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int         BYTES    = HDATA_SIZE / 8;
  localparam int         OFFW     = $clog2(BYTES);
  localparam int         ABITS    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [2:0] MAX_SIZE = 3'(OFFW);

  slv_state_e            state_q, state_d;
  logic                  dphase_q, dphase_d;
  logic                  write_q, write_d;
  logic [ABITS-1:0]      addr_q, addr_d;
  logic [BYTES-1:0]      be_q, be_d;
  logic                  accept_s, err_s, ready_s, done_s;
  logic [BYTES-1:0]      be_s;
  logic [HADDR_SIZE-1:0] waddr_s, align_mask_s;
  logic [HDATA_SIZE-1:0] ram_rdata_s;
  int                    off_s;
  logic                  unused_ctrl;

`ifdef PERIPHERAL_SLAVE_WAIT_STATES_EN
  logic [3:0] cnt_q, cnt_d;
`else
  localparam int unused_wait_states = WAIT_STATES;
`endif

  assign unused_ctrl = ^{HBURST, HPROT, HMASTLOCK};

  // A lane is enabled when it shares the access's HSIZE-aligned block.
  always_comb begin
    waddr_s      = HADDR >> OFFW;
    align_mask_s = '0;
    for (int i = 0; i < HADDR_SIZE; i++) begin
      align_mask_s[i] = (i < int'(HSIZE));
    end
    off_s = int'(HADDR & HADDR_SIZE'(BYTES - 1));
    err_s = (int'(waddr_s) >= MEM_DEPTH) || (HSIZE > MAX_SIZE) ||
            ((HADDR & align_mask_s) != '0);
    for (int b = 0; b < BYTES; b++) begin
      be_s[b] = ((b >> HSIZE) == (off_s >> HSIZE));
    end
  end

  assign ready_s  = (state_q == ST_IDLE) || (state_q == ST_ERR2);
  assign accept_s = ready_s && HSEL && HREADY &&
                    ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
  assign done_s   = dphase_q && (state_q == ST_IDLE);

  always_comb begin
    state_d   = state_q;
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
`ifdef PERIPHERAL_SLAVE_WAIT_STATES_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        HRESP = (state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
        if (accept_s && err_s) begin
          state_d = ST_ERR1;
        end
`ifdef PERIPHERAL_SLAVE_WAIT_STATES_EN
        else if (accept_s && (WAIT_STATES != 0)) begin
          state_d = ST_WAIT;
        end
`endif
        else begin
          state_d = ST_IDLE;
        end
`ifdef PERIPHERAL_SLAVE_WAIT_STATES_EN
        cnt_d = (accept_s && !err_s) ? 4'(WAIT_STATES) : 4'd0;
`endif
      end
`ifdef PERIPHERAL_SLAVE_WAIT_STATES_EN
      ST_WAIT: begin
        HREADYOUT = 1'b0;
        cnt_d     = cnt_q - 4'd1;
        state_d   = (cnt_q <= 4'd1) ? ST_IDLE : ST_WAIT;
      end
`endif
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
        state_d   = ST_ERR2;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control is captured only while this slave is ready; it holds through waits.
  always_comb begin
    dphase_d = dphase_q;
    write_d  = write_q;
    addr_d   = addr_q;
    be_d     = be_q;
    if (ready_s) begin
      dphase_d = accept_s && !err_s;
      if (accept_s) begin
        write_d = HWRITE;
        addr_d  = ABITS'(waddr_s);
        be_d    = be_s;
      end else begin
        write_d = write_q;
      end
    end else begin
      dphase_d = dphase_q;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q  <= ST_IDLE;
      dphase_q <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
    end else begin
      state_q  <= state_d;
      dphase_q <= dphase_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
    end
  end

`ifdef PERIPHERAL_SLAVE_WAIT_STATES_EN
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  always_comb begin
    if (done_s && !write_q) begin
      HRDATA = ram_rdata_s;
    end else begin
      HRDATA = '0;
    end
  end

  peripheral_ram_bb #(
    .DEPTH  (MEM_DEPTH),
    .ABITS  (ABITS),
    .DBYTES (BYTES)
  ) u_ram (
    .clk_i   (HCLK),
    .we_i    (done_s && write_q),
    .addr_i  (addr_q),
    .be_i    (be_q),
    .wdata_i (HWDATA),
    .rdata_o (ram_rdata_s)
  );

endmodule

// File: doc/peripheral_slave_memory_bb.md
PERIPHERAL_SLAVE_MEMORY_BB -- requirements
Module: peripheral_slave_memory_bb

Interface
REQ-001 Parameter HADDR_SIZE, default 16, SHALL set the address bus width in bits.
REQ-002 Parameter HDATA_SIZE, default 32, SHALL set the data bus width in bits (8..1024, power of 2).
REQ-003 Parameter MEM_DEPTH, default 256, SHALL set the memory size in HDATA_SIZE-wide words.
REQ-004 Parameter WAIT_STATES, default 2, SHALL set the wait cycles inserted per data phase (0..15).
REQ-005 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-006 HCLK  in  1  bus clock, all state on rising edge.
REQ-007 HRESET  in  1  asynchronous active-high reset.
REQ-008 HSEL  in  1  slave select.
REQ-009 HADDR  in  HADDR_SIZE  byte address.
REQ-010 HWDATA  in  HDATA_SIZE  write data, data phase.
REQ-011 HRDATA  out  HDATA_SIZE  read data, data phase.
REQ-012 HWRITE / HSIZE / HBURST / HPROT / HTRANS / HMASTLOCK  in  1/3/3/4/2/1  AHB-Lite control; HBURST, HPROT, HMASTLOCK are ignored.
REQ-013 HREADY  in  1  bus ready (HREADYOUT of the selected slave).
REQ-014 HREADYOUT  out  1  this slave's ready.
REQ-015 HRESP  out  1  0=OKAY, 1=ERROR.

Function
REQ-016 A transfer SHALL be accepted when HSEL=1, HREADY=1 and HTRANS is NONSEQ or SEQ; HADDR, HWRITE and HSIZE SHALL be registered at that edge.
REQ-017 IDLE or BUSY, or HSEL=0, SHALL produce a zero-wait OKAY data phase with no memory access.
REQ-018 An accepted transfer SHALL be in error when the word address HADDR/(HDATA_SIZE/8) >= MEM_DEPTH, when HSIZE exceeds the bus width, or when HADDR is not aligned to HSIZE.
REQ-019 The FSM SHALL have the states IDLE, WAIT, ERR1 and ERR2.
REQ-020 IDLE SHALL drive HREADYOUT=1 and HRESP=0.
REQ-021 On an accept in IDLE or WAIT-exit, the FSM SHALL go to ERR1 if the transfer is in error, else to WAIT if the wait counter is loaded non-zero, else stay in IDLE (data phase completes next cycle).
REQ-022 WAIT SHALL drive HREADYOUT=0 and HRESP=0, decrement the counter each cycle, and exit when the counter reaches 0.
REQ-023 ERR1 SHALL drive HREADYOUT=0 and HRESP=1, then go to ERR2.
REQ-024 ERR2 SHALL drive HREADYOUT=1 and HRESP=1, then go to IDLE.
REQ-025 ERR1 SHALL ignore a new accept; ERR2 SHALL accept a new transfer (pipelined).
REQ-026 A write SHALL update only the byte lanes selected by HSIZE and HADDR[log2(HDATA_SIZE/8)-1:0], on the edge ending the OKAY data phase (HREADYOUT=1).
REQ-027 Erroring writes SHALL NOT modify memory.
REQ-028 During an OKAY read data phase, HRDATA SHALL be the full word at the registered address; otherwise HRDATA SHALL be 0.
REQ-029 A read data phase immediately following a write to the same address SHALL return the new data.
REQ-030 Back-to-back transfers with WAIT_STATES=0 SHALL sustain one transfer per cycle.

Reset
REQ-031 Asserting HRESET SHALL immediately force IDLE, counter=0, HREADYOUT=1, HRESP=0, HRDATA=0, and clear the registered control.
REQ-032 Reset mid-transfer SHALL abort the transfer without a memory write; memory contents SHALL NOT be cleared.

Configuration
REQ-033 With PERIPHERAL_SLAVE_WAIT_STATES_EN defined, the wait counter SHALL be loaded with WAIT_STATES on each accept.
REQ-034 Without PERIPHERAL_SLAVE_WAIT_STATES_EN, the WAIT state and counter SHALL be absent and every OKAY data phase SHALL complete with zero waits, regardless of WAIT_STATES.

Structure
REQ-035 HTRANS_*, HSIZE_*, HBURST_* and HRESP_OKAY/HRESP_ERROR constants, plus the FSM state enum, SHALL reside in peripheral_bb_pkg.
REQ-036 Storage SHALL be a sub-module peripheral_ram_bb: a single-port, byte-enabled RAM with combinational read.

Verification
REQ-037 Write word 0xDEADBEEF to 0x0010, then read 0x0010 -> HRDATA=0xDEADBEEF, HRESP=0, with WAIT_STATES=2 waits per phase.
REQ-038 Byte write 0xAA to 0x0013 over word 0x11223344 -> readback 0xAA223344.
REQ-039 Read 0x0400 (word 256, MEM_DEPTH=256) -> ERR1 then ERR2 (HREADYOUT 0 then 1, HRESP=1), memory unchanged.
REQ-040 Halfword access at 0x0001 -> two-cycle ERROR response.
REQ-041 INCR4 write burst 1,2,3,4 at 0x0020 with macro undefined -> four consecutive HREADYOUT=1 cycles, readback 1,2,3,4.
REQ-042 Assert HRESET during the WAIT of a write to 0x0030 -> outputs reset immediately, word 0x0030 keeps its prior value.
